multicycle_controller: RTL

Multicycle sequencer for the RV32I core. It replaces single-cycle control decoding with a state machine that time-shares one ALU and one unified memory across fetch, decode, execute and writeback. It consumes opcode/funct fields from the instruction register and the ALU flags. It drives every datapath mux select and write strobe, and handshakes with a variable-latency memory.

---
 rtl/multicycle_controller.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control sequencer: one shared ALU and one unified memory.
// Define RETIRE_CNT_EN to build the retired-instruction counter; otherwise retired_count reads 0.
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             Negative,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [4:0]       ALUControl,
    output logic [2:0]       ImmSrc,
    output logic             illegal_instr,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11
    } state_t;

    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR = 5'd3,
                           ALU_XOR = 5'd4, ALU_SLT = 5'd5, ALU_SLL = 5'd6, ALU_SRL = 5'd7,
                           ALU_SRA = 5'd8, ALU_SLTU = 5'd9, ALU_PASSB = 5'd10;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_LUI = 7'b0110111;

    state_t     state_reg, state_next;
    logic [4:0] alu_base, alu_r;
    logic       taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= state_t'(RESET_STATE);
        else        state_reg <= state_next;
    end

    assign state = state_reg;

    // Immediate ops ignore funct7b5 on funct3=000 (addi has no subtract form).
    always_comb begin
        alu_base = ALU_ADD;
        case (funct3)
            3'b000: alu_base = ALU_ADD;
            3'b001: alu_base = ALU_SLL;
            3'b010: alu_base = ALU_SLT;
            3'b011: alu_base = ALU_SLTU;
            3'b100: alu_base = ALU_XOR;
            3'b101: alu_base = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_base = ALU_OR;
            default: alu_base = ALU_AND;
        endcase
        alu_r = (funct3 == 3'b000 && funct7b5) ? ALU_SUB : alu_base;
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = !Zero;
            3'b100:  taken = Negative;
            3'b101:  taken = !Negative;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        mem_req       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        ImmSrc        = IMM_I;
        illegal_instr = 1'b0;
        // Outputs are forced quiet for the whole reset interval, even though state reads FETCH.
        if (rst_n) begin
            case (state_reg)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                    if (mem_ready) state_next = S_DECODE;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                    case (op)
                        OP_LOAD, OP_STORE: state_next = S_MEMADR;
                        OP_R:              state_next = S_EXECR;
                        OP_I:              state_next = S_EXECI;
                        OP_BR:             state_next = S_BRANCH;
                        OP_JAL:            state_next = S_JAL;
                        OP_LUI:            state_next = S_LUI;
                        default: begin
                            state_next    = S_FETCH;
                            illegal_instr = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b01;
                    ImmSrc     = op[5] ? IMM_S : IMM_I;
                    state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                    if (mem_ready) state_next = S_MEMWB;
                end
                S_MEMWB: begin
                    ResultSrc  = 2'b01;
                    RegWrite   = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                    if (mem_ready) state_next = S_FETCH;
                end
                S_EXECR: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = alu_r;
                    state_next = S_ALUWB;
                end
                S_EXECI: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b01;
                    ALUControl = alu_base;
                    state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite   = 1'b1;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = ALU_SUB;
                    PCWrite    = taken;
                    state_next = S_FETCH;
                end
                S_JAL: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b10;
                    PCWrite    = 1'b1;
                    state_next = S_ALUWB;
                end
                S_LUI: begin
                    ALUSrcB    = 2'b01;
                    ImmSrc     = IMM_U;
                    ALUControl = ALU_PASSB;
                    state_next = S_ALUWB;
                end
                default: state_next = S_FETCH;
            endcase
        end
    end

`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] count_reg;
    logic             retire;

    assign retire = (state_next == S_FETCH) && (state_reg != S_FETCH) && !illegal_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      count_reg <= '0;
        else if (retire) count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign retired_count = count_reg;
`else
    assign retired_count = '0;
`endif

endmodule
